// File: rtl/mdu_pkg.sv
// ============================================================================
// mdu_pkg : shared decode constants and FSM encoding for the mult/div sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_ITER = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_t;

    function automatic logic is_muldiv(input logic [5:0] f);
        return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
    endfunction

    function automatic logic is_hilo_op(input logic [5:0] f);
        return is_muldiv(f) || (f == FN_MFHI) || (f == FN_MTHI) ||
               (f == FN_MFLO) || (f == FN_MTLO);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_if.sv
// ============================================================================
// mdu_if : EX-stage request / HI-LO response bundle for the mult/div sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             flush;
    logic             stall;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mf_data;

    modport master (
        output valid, alu_op, funct, rs_val, rt_val, flush,
        input  stall, busy, hi, lo, mf_data
    );

    modport slave (
        input  valid, alu_op, funct, rs_val, rt_val, flush,
        output stall, busy, hi, lo, mf_data
    );
endinterface

`default_nettype wire

// File: rtl/mdu_iter_core.sv
// ============================================================================
// mdu_iter_core : shift-add multiplier / restoring divider datapath with sign fix
// Revision: 1.0
// ============================================================================
`default_nettype none

module mdu_iter_core #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             start,
    input  wire logic             is_div,
    input  wire logic             is_signed,
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    input  wire logic             prep,
    input  wire logic             step,
    output logic      [WIDTH-1:0] res_hi,
    output logic      [WIDTH-1:0] res_lo
);

    logic [WIDTH-1:0] r_a, r_b, r_acc, r_q, r_m;
    logic             r_div, r_sgn, r_neg_res, r_neg_rem, r_dz;

    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic [WIDTH:0]     w_sum, w_shrem, w_diff;
    logic [2*WIDTH-1:0] w_prod;

    always_comb begin
        w_abs_a = (r_sgn && r_a[WIDTH-1]) ? -r_a : r_a;
        w_abs_b = (r_sgn && r_b[WIDTH-1]) ? -r_b : r_b;
        w_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
        w_shrem = {r_acc, r_q[WIDTH-1]};
        w_diff  = w_shrem - {1'b0, r_m};
        w_prod  = r_neg_res ? -{r_acc, r_q} : {r_acc, r_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_m       <= '0;
            r_div     <= 1'b0;
            r_sgn     <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
        end else if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_div <= is_div;
            r_sgn <= is_signed;
        end else if (prep) begin
            r_acc     <= '0;
            r_q       <= r_div ? w_abs_a : w_abs_b;
            r_m       <= r_div ? w_abs_b : w_abs_a;
            r_neg_res <= r_sgn & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
            r_neg_rem <= r_sgn & r_a[WIDTH-1];
            r_dz      <= r_div & (r_b == '0);
        end else if (step) begin
            if (r_div) begin
                // Restoring step: keep the trial difference only if it stayed non-negative
                if (!w_diff[WIDTH]) begin
                    r_acc <= w_diff[WIDTH-1:0];
                    r_q   <= {r_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_acc <= w_shrem[WIDTH-1:0];
                    r_q   <= {r_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                r_acc <= w_sum[WIDTH:1];
                r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        res_hi = w_prod[2*WIDTH-1:WIDTH];
        res_lo = w_prod[WIDTH-1:0];
        if (r_div) begin
            if (r_dz) begin
                res_hi = r_a;
                res_lo = '1;
            end else begin
                res_hi = r_neg_rem ? -r_acc : r_acc;
                res_lo = r_neg_res ? -r_q : r_q;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mdu_sequencer.sv
// ============================================================================
// mdu_sequencer : EX-stage multi-cycle mult/div sequencer owning HI/LO and stall
// Revision: 1.0
// ============================================================================
`default_nettype none

module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input wire logic clk,
    input wire logic rst_n,
    mdu_if.slave     bus
);

    mdu_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [WIDTH-1:0] r_hi, r_lo;

    logic             w_op_ok, w_accept, w_signed, w_is_div;
    logic [WIDTH-1:0] w_res_hi, w_res_lo;

    always_comb begin
        w_op_ok  = bus.valid && (bus.alu_op == ALUOP_RTYPE);
        w_accept = (r_state == ST_IDLE) && w_op_ok && is_muldiv(bus.funct) && !bus.flush;
        w_signed = (bus.funct == FN_MULT) || (bus.funct == FN_DIV);
        w_is_div = (bus.funct == FN_DIV) || (bus.funct == FN_DIVU);
    end

    mdu_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (w_accept),
        .is_div    (w_is_div),
        .is_signed (w_signed),
        .a         (bus.rs_val),
        .b         (bus.rt_val),
        .prep      (r_state == ST_PREP),
        .step      (r_state == ST_ITER),
        .res_hi    (w_res_hi),
        .res_lo    (w_res_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_PREP;
                        r_busy  <= 1'b1;
                    end else if (w_op_ok && !bus.flush) begin
                        if (bus.funct == FN_MTHI) r_hi <= bus.rs_val;
                        if (bus.funct == FN_MTLO) r_lo <= bus.rs_val;
                    end
                end
                ST_PREP: begin
                    if (bus.flush) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_ITER;
                        r_cnt   <= CNT_W'(WIDTH - 1);
                    end
                end
                ST_ITER: begin
                    if (bus.flush) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_state <= ST_FIX;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    // A flush landing on the final cycle still kills the result
                    if (!bus.flush) begin
                        r_hi <= w_res_hi;
                        r_lo <= w_res_lo;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stall   = rst_n && ((r_busy && w_op_ok && is_hilo_op(bus.funct)) || w_accept);
    assign bus.busy    = r_busy;
    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;
    assign bus.mf_data = (w_op_ok && bus.funct == FN_MFHI) ? r_hi :
                         (w_op_ok && bus.funct == FN_MFLO) ? r_lo : '0;

endmodule

`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
// ============================================================================
// tb_mdu_sequencer : scoreboard bench for the mult/div sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mdu_sequencer;

    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [63:0] exp_q[$];

    mdu_if #(.WIDTH(32)) bus ();

    mdu_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic signed [31:0] qa, qb;
        sa = 64'(signed'(a));
        sb = 64'(signed'(b));
        qa = a;
        qb = b;
        case (f)
            F_MULTU: return {32'h0, a} * {32'h0, b};
            F_MULT:  return sa * sb;
            F_DIVU:  return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(qa % qb), 32'(qa / qb)};
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.valid  = 1'b1;
        bus.alu_op = 2'b10;
        bus.funct  = f;
        bus.rs_val = a;
        bus.rt_val = b;
    endtask

    task automatic accept_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        drive(f, a, b);
        #1;
        chk("accept_stall", {63'h0, bus.stall}, 64'h1);
        tick();
        bus.valid = 1'b0;
    endtask

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int n;
        logic [63:0] e;
        exp_q.push_back(model(f, a, b));
        accept_op(f, a, b);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            tick();
        end
        chk("busy_cycles", 64'(n), 64'd34);
        e = exp_q.pop_front();
        chk("hi", {32'h0, bus.hi}, {32'h0, e[63:32]});
        chk("lo", {32'h0, bus.lo}, {32'h0, e[31:0]});
    endtask

    task automatic preload(input logic [31:0] h, input logic [31:0] l);
        drive(F_MTHI, h, 0);
        #1;
        chk("mt_no_stall", {63'h0, bus.stall}, 64'h0);
        tick();
        drive(F_MTLO, l, 0);
        tick();
        bus.valid = 1'b0;
        chk("preload_hi", {32'h0, bus.hi}, {32'h0, h});
        chk("preload_lo", {32'h0, bus.lo}, {32'h0, l});
    endtask

    initial begin
        int n, st;
        logic [63:0] e;
        logic [5:0] fsel[4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
        rst_n      = 1'b0;
        bus.valid  = 1'b0;
        bus.alu_op = 2'b00;
        bus.funct  = 6'h0;
        bus.rs_val = 32'h0;
        bus.rt_val = 32'h0;
        bus.flush  = 1'b0;
        tick();
        tick();
        chk("rst_busy", {63'h0, bus.busy}, 64'h0);
        chk("rst_hi", {32'h0, bus.hi}, 64'h0);
        chk("rst_lo", {32'h0, bus.lo}, 64'h0);
        chk("rst_stall", {63'h0, bus.stall}, 64'h0);
        rst_n = 1'b1;
        tick();

        run_op(F_MULTU, 32'hFFFF_FFFF, 32'd2);
        run_op(F_MULT, 32'hFFFF_FFFD, 32'd7);
        run_op(F_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op(F_DIV, 32'h1234_5678, 32'd0);
        run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(F_DIVU, 32'hDEAD_BEEF, 32'd0);

        // DIVU followed by a dependent MFLO held in EX
        exp_q.push_back(model(F_DIVU, 32'd100, 32'd7));
        accept_op(F_DIVU, 32'd100, 32'd7);
        drive(F_MFLO, 0, 0);
        #1;
        n = 0; st = 0;
        while (bus.busy && n < 100) begin
            if (bus.stall) st++;
            n++;
            tick();
        end
        chk("mflo_stall_cycles", 64'(st), 64'd34);
        e = exp_q.pop_front();
        chk("mflo_no_stall", {63'h0, bus.stall}, 64'h0);
        chk("mflo_data", {32'h0, bus.mf_data}, {32'h0, e[31:0]});
        chk("divu_hi", {32'h0, bus.hi}, {32'h0, e[63:32]});
        bus.valid = 1'b0;

        for (int i = 0; i < 6; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i == 3) ? 32'h0 : $urandom;
            run_op(fsel[i % 4], ra, rb);
        end

        // Flush mid-ITER
        preload(32'h0000_AAAA, 32'h0000_5555);
        accept_op(F_MULT, 32'd5, 32'd6);
        repeat (9) tick();
        bus.flush = 1'b1;
        #1;
        chk("flush_busy_before", {63'h0, bus.busy}, 64'h1);
        tick();
        bus.flush = 1'b0;
        chk("flush_busy_after", {63'h0, bus.busy}, 64'h0);
        chk("flush_hi", {32'h0, bus.hi}, 64'h0000_AAAA);
        chk("flush_lo", {32'h0, bus.lo}, 64'h0000_5555);
        drive(F_MFHI, 0, 0);
        #1;
        chk("mfhi_data", {32'h0, bus.mf_data}, 64'h0000_AAAA);

        // Flush on the IDLE accept edge: nothing taken, no MT write
        drive(F_MULT, 32'd9, 32'd9);
        bus.flush = 1'b1;
        #1;
        chk("flush_accept_stall", {63'h0, bus.stall}, 64'h0);
        tick();
        chk("flush_accept_busy", {63'h0, bus.busy}, 64'h0);
        drive(F_MTHI, 32'h1234, 0);
        tick();
        chk("flush_mthi", {32'h0, bus.hi}, 64'h0000_AAAA);
        bus.flush = 1'b0;
        bus.valid = 1'b0;

        // Flush during FIX
        accept_op(F_MULTU, 32'd3, 32'd3);
        repeat (33) tick();
        bus.flush = 1'b1;
        #1;
        chk("fix_flush_busy", {63'h0, bus.busy}, 64'h1);
        tick();
        bus.flush = 1'b0;
        chk("fix_flush_idle", {63'h0, bus.busy}, 64'h0);
        chk("fix_flush_hi", {32'h0, bus.hi}, 64'h0000_AAAA);
        chk("fix_flush_lo", {32'h0, bus.lo}, 64'h0000_5555);

        // Async reset mid-ITER
        accept_op(F_MULT, 32'd11, 32'd13);
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {63'h0, bus.busy}, 64'h0);
        chk("arst_hi", {32'h0, bus.hi}, 64'h0);
        chk("arst_lo", {32'h0, bus.lo}, 64'h0);
        chk("arst_stall", {63'h0, bus.stall}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_op(F_MULT, 32'd11, 32'd13);

        chk("sb_empty", 64'(exp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide sequencer for the EX stage.
- Decodes R-type MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO function codes alongside the ALU control path.
- Runs an iterative shift-add multiplier or restoring divider over HI/LO, and holds the pipeline via stall while a result is pending.
- Sits beside the single-cycle ALU; reads rs/rt operands from the forwarding muxes and returns HI/LO data for MFHI/MFLO writeback.

Parameters:
- WIDTH, 32, operand and HI/LO register width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- valid  input  1  EX-stage instruction valid.
- alu_op  input  2  main-control ALUOp; only 2'b10 (R-type) is decoded.
- funct  input  6  instruction function code.
- rs_val  input  WIDTH  operand A: multiplicand, dividend, or MTHI/MTLO data.
- rt_val  input  WIDTH  operand B: multiplier or divisor.
- flush  input  1  kill the in-flight operation (branch/exception flush).
- stall  output  1  combinational; holds IF/ID/EX.
- busy  output  1  registered; state != IDLE.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- mf_data  output  WIDTH  combinational; hi for MFHI, lo for MFLO, else 0.

Behaviour:
Decode
- op_ok = valid && alu_op==2'b10.
- Function codes: MULT 6'h18, MULTU 6'h19, DIV 6'h1A, DIVU 6'h1B, MFHI 6'h10, MTHI 6'h11, MFLO 6'h12, MTLO 6'h13.
- Other functs are ignored.

Reset
- Async on rst_n low: state=IDLE, hi=0, lo=0, counter=0, internal accumulators=0.
- busy=0; stall=0 while reset is held.
- Reset mid-operation discards all work.

States: IDLE, PREP, ITER, FIX.
- IDLE: a mult/div op with flush=0 is accepted on this edge. Operands and signedness are latched; go to PREP.
- IDLE, MTHI/MTLO: write hi/lo from rs_val on this edge; stay IDLE; no stall.
- PREP (1 cycle): for signed ops, take absolute values and record the result signs. Unsigned ops pass through. Load counter=WIDTH-1. Go to ITER.
- ITER (WIDTH cycles): one shift-add or restoring-subtract step per cycle. Counter decrements; at counter==0 go to FIX.
- FIX (1 cycle): apply sign correction.
  - Product is negated if operand signs differ.
  - Quotient is negated if signs differ; remainder takes the dividend's sign.
  - Write hi/lo; go to IDLE.

Latency
- Accept edge to hi/lo updated: WIDTH+2 cycles (34 at default). Uniform for all four ops.
- MULT/MULTU: hi=upper half, lo=lower half of the 2*WIDTH product.
- DIV/DIVU: lo=quotient, hi=remainder.

stall, computed combinationally:
- busy && op_ok && funct is any of the eight decoded codes; or
- the IDLE cycle in which a mult/div op is accepted.
- Effect: the issuing instruction advances exactly once. A dependent MFHI/MFLO/MTHI/MTLO or a second mult/div is held until the FIX edge completes. It is then decoded in IDLE: an MF* reads the new value; a new mult/div is accepted.

Boundary conditions
- Divide by zero (either signedness): lo={WIDTH{1'b1}}, hi=original rs_val. No trap, same latency.
- Signed overflow (most-negative / -1): lo=most-negative, hi=0.
- flush while busy: next state IDLE; hi/lo keep their previous values; busy drops next cycle.
- flush in the IDLE accept cycle: nothing is accepted; no MT* write.
- flush during the FIX cycle: flush wins, hi/lo are not written.
- Never stall and flush together on an accepting edge: flush has priority.

Decomposition:
- Package mdu_pkg: funct code constants, state encoding (2-bit enum), ALUOP_RTYPE constant.
- Sub-module mdu_iter_core: holds the PREP/ITER/FIX datapath (accumulator, shift registers, sign flags).
- mdu_sequencer keeps decode, FSM, counter, stall and hi/lo registers.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=2 -> after 34 cycles hi=0x00000001, lo=0xFFFFFFFE; busy high exactly 34 cycles.
- MULT rs=-3, rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=100, rt=7, followed by MFLO -> stall held 34 cycles; MFLO then sees mf_data=14; hi=2.
- DIV rs=0x12345678, rt=0 -> lo=0xFFFFFFFF, hi=0x12345678. DIV rs=0x80000000, rt=-1 -> lo=0x80000000, hi=0.
- Preload MTHI 0xAAAA / MTLO 0x5555; issue MULT; flush at cycle 10 -> IDLE next cycle, hi/lo unchanged.
- Repeat the flush test with rst_n pulsed low mid-ITER instead -> hi=lo=0, busy=0 immediately.
